dmem_req_ctrl: RTL and testbench

Initiator-side controller that drives the byte-column data-memory interface: valid_st, spec_ld, per-column we, word addr, din/dout with a registered read port. It accepts one CPU load/store request at a time over a valid/ready handshake and generates the word address and column write enables. It also aligns and sign-extends load data and returns a single-cycle response pulse. It sits between the pipeline's memory stage and the data memory.

---
 rtl/dmem_req_pkg.sv | 49 ++++
 rtl/dmem_ld_align.sv | 29 ++
 rtl/dmem_req_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_dmem_req_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_req_pkg.sv
// Shared types and helpers for the data-memory request controller.
// DMEM_REQ_MISALIGN_EN widens the byte enables and adds the split-access states.
package dmem_req_pkg;

    localparam int WORD_BYTES = 4;

`ifdef DMEM_REQ_MISALIGN_EN
    localparam int BE_W = 2 * WORD_BYTES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST_ISSUE,
        S_LD_ISSUE,
        S_LD_CAPT,
        S_RSP,
        S_ST_ISSUE2,
        S_LD_ISSUE2,
        S_LD_CAPT2
    } state_e;
`else
    localparam int BE_W = WORD_BYTES;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST_ISSUE,
        S_LD_ISSUE,
        S_LD_CAPT,
        S_RSP
    } state_e;
`endif

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    // Byte enables for an access; upper half is the spill into the next word.
    function automatic logic [BE_W-1:0] be_gen(size_e size, logic [1:0] offset);
        logic [BE_W-1:0] base;
        case (size)
            SZ_B:    base = BE_W'(4'h1);
            SZ_H:    base = BE_W'(4'h3);
            default: base = BE_W'(4'hF);
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/dmem_ld_align.sv
// Load-data alignment: picks the addressed byte/half from one or two words
// (low word first) and sign- or zero-extends it to 32 bits.
module dmem_ld_align
    import dmem_req_pkg::*;
(
    input  logic [31:0] word_lo_i,
    input  logic [31:0] word_hi_i,
    input  logic [1:0]  offset_i,
    input  size_e       size_i,
    input  logic        uns_i,
    output logic [31:0] data_o
);

    logic [31:0] aligned;

    assign aligned = 32'({word_hi_i, word_lo_i} >> {offset_i, 3'b000});

    always_comb begin
        data_o = aligned;
        case (size_i)
            SZ_B:    data_o = uns_i ? {24'b0, aligned[7:0]}
                                    : {{24{aligned[7]}}, aligned[7:0]};
            SZ_H:    data_o = uns_i ? {16'b0, aligned[15:0]}
                                    : {{16{aligned[15]}}, aligned[15:0]};
            default: data_o = aligned;
        endcase
    end

endmodule

// File: rtl/dmem_req_ctrl.sv
// Single-outstanding load/store controller for a byte-column data memory.
// DMEM_REQ_MISALIGN_EN splits misaligned accesses into two word accesses.
module dmem_req_ctrl
    import dmem_req_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int COL_WIDTH  = 8,
    parameter int NB_COL     = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_st,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_is_st,
    output logic [31:0]           rsp_data,
    output logic                  rsp_err,
    output logic                  mem_valid_st,
    output logic                  mem_spec_ld,
    output logic [NB_COL-1:0]     mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    input  logic [31:0]           mem_dout
);

    state_e                state_q;
    size_e                 size_q;
    logic                  uns_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  rsp_valid_q, rsp_is_st_q, rsp_err_q;
    logic [31:0]           rsp_data_q;

    size_e                 req_sz;
    logic [BE_W-1:0]       be;
    logic [ADDR_WIDTH-1:0] word_a;
    logic                  st_iss, ld_iss;
    logic [31:0]           ld_word_lo, ld_word_hi, ld_data;

    assign req_sz = (req_size == 2'd3) ? SZ_W : size_e'(req_size);
    assign be     = be_gen(size_q, addr_q[1:0]);
    assign word_a = addr_q[ADDR_WIDTH+1:2];

    dmem_ld_align u_align (
        .word_lo_i (ld_word_lo),
        .word_hi_i (ld_word_hi),
        .offset_i  (addr_q[1:0]),
        .size_i    (size_q),
        .uns_i     (uns_q),
        .data_o    (ld_data)
    );

`ifdef DMEM_REQ_MISALIGN_EN
    logic        split, second;
    logic [31:0] lo_q, wdata_sz;
    logic [63:0] st_lanes;

    assign split  = |be[BE_W-1:WORD_BYTES];
    assign second = (state_q == S_ST_ISSUE2) || (state_q == S_LD_ISSUE2);
    assign st_iss = (state_q == S_ST_ISSUE) || (state_q == S_ST_ISSUE2);
    assign ld_iss = (state_q == S_LD_ISSUE) || (state_q == S_LD_ISSUE2);

    always_comb begin
        wdata_sz = wdata_q;
        case (size_q)
            SZ_B:    wdata_sz = {24'b0, wdata_q[7:0]};
            SZ_H:    wdata_sz = {16'b0, wdata_q[15:0]};
            default: wdata_sz = wdata_q;
        endcase
    end

    // Store data shifted across a two-word window; the high word feeds the spill access.
    assign st_lanes   = {32'b0, wdata_sz} << {addr_q[1:0], 3'b000};
    assign mem_we     = st_iss ? (second ? be[BE_W-1:WORD_BYTES] : be[WORD_BYTES-1:0]) : '0;
    assign mem_din    = st_iss ? (second ? st_lanes[63:32] : st_lanes[31:0]) : '0;
    assign mem_addr   = (st_iss || ld_iss) ? (second ? word_a + ADDR_WIDTH'(1) : word_a) : '0;
    assign ld_word_lo = (state_q == S_LD_CAPT2) ? lo_q : mem_dout;
    assign ld_word_hi = (state_q == S_LD_CAPT2) ? mem_dout : '0;
`else
    logic        req_misal;
    logic [31:0] din_rep;

    assign req_misal = ((req_sz == SZ_H) && req_addr[0]) ||
                       ((req_sz == SZ_W) && (req_addr[1:0] != 2'b00));
    assign st_iss    = (state_q == S_ST_ISSUE);
    assign ld_iss    = (state_q == S_LD_ISSUE);

    always_comb begin
        din_rep = wdata_q;
        case (size_q)
            SZ_B:    din_rep = {NB_COL{wdata_q[COL_WIDTH-1:0]}};
            SZ_H:    din_rep = {(NB_COL/2){wdata_q[2*COL_WIDTH-1:0]}};
            default: din_rep = wdata_q;
        endcase
    end

    assign mem_we     = st_iss ? be[NB_COL-1:0] : '0;
    assign mem_din    = st_iss ? din_rep : '0;
    assign mem_addr   = (st_iss || ld_iss) ? word_a : '0;
    assign ld_word_lo = mem_dout;
    assign ld_word_hi = '0;
`endif

    assign mem_valid_st = st_iss;
    assign mem_spec_ld  = ld_iss;
    assign req_ready    = (state_q == S_IDLE);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_is_st    = rsp_is_st_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_err      = rsp_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_is_st_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
`ifdef DMEM_REQ_MISALIGN_EN
            lo_q        <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        size_q  <= req_sz;
                        uns_q   <= req_unsigned;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        state_q <= req_is_st ? S_ST_ISSUE : S_LD_ISSUE;
`ifndef DMEM_REQ_MISALIGN_EN
                        if (req_misal) begin
                            state_q     <= S_RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_is_st_q <= req_is_st;
                        end
`endif
                    end
                end
                S_ST_ISSUE: begin
                    state_q     <= S_RSP;
                    rsp_valid_q <= 1'b1;
                    rsp_is_st_q <= 1'b1;
`ifdef DMEM_REQ_MISALIGN_EN
                    if (split) begin
                        state_q     <= S_ST_ISSUE2;
                        rsp_valid_q <= 1'b0;
                        rsp_is_st_q <= 1'b0;
                    end
`endif
                end
                S_LD_ISSUE: state_q <= S_LD_CAPT;
                S_LD_CAPT: begin
                    state_q     <= S_RSP;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= ld_data;
`ifdef DMEM_REQ_MISALIGN_EN
                    if (split) begin
                        lo_q        <= mem_dout;
                        state_q     <= S_LD_ISSUE2;
                        rsp_valid_q <= 1'b0;
                        rsp_data_q  <= '0;
                    end
`endif
                end
`ifdef DMEM_REQ_MISALIGN_EN
                S_ST_ISSUE2: begin
                    state_q     <= S_RSP;
                    rsp_valid_q <= 1'b1;
                    rsp_is_st_q <= 1'b1;
                end
                S_LD_ISSUE2: state_q <= S_LD_CAPT2;
                S_LD_CAPT2: begin
                    state_q     <= S_RSP;
                    rsp_valid_q <= 1'b1;
                    rsp_data_q  <= ld_data;
                end
`endif
                S_RSP: begin
                    state_q     <= S_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_is_st_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_data_q  <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Bench for dmem_req_ctrl: a word memory answers the strobes, and a byte-array
// reference model predicts every strobe, enable, lane and response.
module tb_dmem_req_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_st;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_is_st;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        mem_valid_st;
    logic        mem_spec_ld;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    int checks;
    int failures;

    logic [31:0] mem_arr [0:1023];
    logic [7:0]  ref_mem [0:4095];
    logic        fill_en;

    dmem_req_ctrl #(.ADDR_WIDTH(10), .COL_WIDTH(8), .NB_COL(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_st    (req_is_st),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_is_st    (rsp_is_st),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .mem_valid_st (mem_valid_st),
        .mem_spec_ld  (mem_spec_ld),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] fill_word(int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Byte-column memory with a registered read port.
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 1024; i++) mem_arr[i] <= fill_word(i);
            mem_dout <= 32'h0;
        end else begin
            if (mem_valid_st)
                for (int c = 0; c < 4; c++)
                    if (mem_we[c]) mem_arr[mem_addr][8*c +: 8] <= mem_din[8*c +: 8];
            if (mem_spec_ld) mem_dout <= mem_arr[mem_addr];
        end
    end

    function automatic logic [31:0] ref_load(logic [11:0] a, int n, bit uns);
        logic [31:0] v;
        v = 32'h0;
        for (int b = 0; b < n; b++) v = v | (32'(ref_mem[12'(a + 12'(b))]) << (8 * b));
        if (!uns && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request at a negedge with the DUT idle; returns at the negedge after the response.
    task automatic do_req(input bit is_st, input logic [1:0] size, input bit uns,
                          input logic [11:0] addr, input logic [31:0] wdata, input bit hold);
        int          n, off, lat;
        bit          mis;
        logic [31:0] exp_data, exp_din;
        logic [3:0]  exp_we;
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        off = int'(addr[1:0]);
        mis = (n == 2 && addr[0]) || (n == 4 && off != 0);
        lat = mis ? 1 : (is_st ? 2 : 3);
        exp_data = (is_st || mis) ? 32'h0 : ref_load(addr, n, uns);
        exp_we = 4'h0;
        for (int b = 0; b < n; b++) exp_we = exp_we | (4'h1 << (off + b));
        exp_din = (n == 1) ? {4{wdata[7:0]}} : (n == 2) ? {2{wdata[15:0]}} : wdata;

        chk("ready_idle", 32'(req_ready), 32'd1);
        req_is_st    = is_st;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk("ready_busy", 32'(req_ready), 32'd0);
            chk("mem_valid_st", 32'(mem_valid_st), 32'(!mis && is_st && k == 1));
            chk("mem_spec_ld", 32'(mem_spec_ld), 32'(!mis && !is_st && k == 1));
            if (!mis && k == 1) chk("mem_addr", 32'(mem_addr), 32'(addr[11:2]));
            if (!mis && is_st && k == 1) begin
                chk("mem_we", 32'(mem_we), 32'(exp_we));
                chk("mem_din", mem_din, exp_din);
            end else begin
                chk("mem_we_idle", 32'(mem_we), 32'd0);
            end
            chk("rsp_valid", 32'(rsp_valid), 32'(k == lat));
            if (k == lat) begin
                chk("rsp_is_st", 32'(rsp_is_st), 32'(is_st));
                chk("rsp_err", 32'(rsp_err), 32'(mis));
                chk("rsp_data", rsp_data, exp_data);
            end
        end
        @(negedge clk);
        chk("rsp_valid_after", 32'(rsp_valid), 32'd0);
        chk("rsp_fields_after", {rsp_data[29:0], rsp_is_st, rsp_err}, 32'd0);
        chk("ready_after", 32'(req_ready), 32'd1);
        if (is_st && !mis)
            for (int b = 0; b < n; b++) ref_mem[12'(addr + 12'(b))] = wdata[8*b +: 8];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        fill_en      = 1'b1;
        req_valid    = 1'b0;
        req_is_st    = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 12'h0;
        req_wdata    = 32'h0;
        for (int i = 0; i < 4096; i++) begin
            logic [31:0] w;
            w = fill_word(i / 4);
            ref_mem[i] = w[8*(i%4) +: 8];
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp", {rsp_data[29:0], rsp_valid, rsp_err}, 32'd0);
        chk("reset_mem", {mem_din[20:0], mem_valid_st, mem_spec_ld, mem_we, mem_addr[3:0]}, 32'd0);
        fill_en = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);

        do_req(1'b1, 2'd2, 1'b0, 12'h010, 32'hDEAD_BEEF, 1'b0);
        do_req(1'b1, 2'd0, 1'b0, 12'h013, 32'h1234_56A5, 1'b0);
        do_req(1'b0, 2'd0, 1'b0, 12'h013, 32'h0, 1'b0);
        do_req(1'b0, 2'd0, 1'b1, 12'h013, 32'h0, 1'b0);
        do_req(1'b1, 2'd2, 1'b0, 12'h010, 32'h8001_7FFF, 1'b0);
        do_req(1'b0, 2'd1, 1'b0, 12'h012, 32'h0, 1'b0);
        do_req(1'b0, 2'd1, 1'b0, 12'h010, 32'h0, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 12'h011, 32'h0, 1'b0);
        do_req(1'b1, 2'd1, 1'b0, 12'h015, 32'hBEEF_0000, 1'b0);
        do_req(1'b1, 2'd3, 1'b0, 12'h020, 32'h0BAD_F00D, 1'b0);
        do_req(1'b0, 2'd3, 1'b1, 12'h020, 32'h0, 1'b0);
        do_req(1'b1, 2'd2, 1'b0, 12'hFFC, 32'hCAFE_F00D, 1'b0);
        do_req(1'b0, 2'd2, 1'b0, 12'hFFC, 32'h0, 1'b0);
        do_req(1'b1, 2'd1, 1'b0, 12'h01E, 32'h0000_9ABC, 1'b1);
        do_req(1'b0, 2'd1, 1'b0, 12'h01E, 32'h0, 1'b1);
        do_req(1'b0, 2'd0, 1'b1, 12'h01F, 32'h0, 1'b0);

        for (int r = 0; r < 60; r++) begin
            do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   12'($urandom_range(0, 47)), $urandom, 1'($urandom_range(0, 1)));
        end

        // Reset while the load is in its capture cycle.
        req_is_st    = 1'b0;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_addr     = 12'h010;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_pre_spec_ld", 32'(mem_spec_ld), 32'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(req_ready), 32'd1);
        chk("rst_mid_rsp", {rsp_data[29:0], rsp_valid, rsp_err}, 32'd0);
        chk("rst_mid_mem", {mem_din[20:0], mem_valid_st, mem_spec_ld, mem_we, mem_addr[3:0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        do_req(1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
